// File: rtl/sr_ff_monitor.sv
// rtl/sr_ff_monitor.sv - reference-model checker for SR-behaving flops
// Observes s/r/q/qbar each rising edge; flags mismatches and illegal s=r=1 inputs.
module sr_ff_monitor #(
   parameter int CNT_W = 8,
   parameter int CYC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             s,
   input  logic             r,
   input  logic             q,
   input  logic             qbar,
   output logic             exp_q,
   output logic             synced,
   output logic             mismatch,
   output logic             illegal,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] illegal_count,
   output logic [CYC_W-1:0] cyc_count,
   output logic             first_err_valid,
   output logic [CYC_W-1:0] first_err_cyc
);

   typedef enum logic {SYNC, TRACK} state_t;

   state_t           state_q, state_d;
   logic             exp_q_q, exp_q_d;
   logic             mismatch_q, mismatch_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [CNT_W-1:0] illegal_count_q, illegal_count_d;
   logic [CYC_W-1:0] cyc_count_q, cyc_count_d;
   logic             first_err_valid_q, first_err_valid_d;
   logic [CYC_W-1:0] first_err_cyc_q, first_err_cyc_d;

   logic             err_hit;
   logic             ill_hit;
   logic             model_base;

   always_comb begin
      state_d           = state_q;
      exp_q_d           = exp_q_q;
      mismatch_d        = 1'b0;
      illegal_d         = 1'b0;
      err_count_d       = err_count_q;
      illegal_count_d   = illegal_count_q;
      cyc_count_d       = cyc_count_q;
      first_err_valid_d = first_err_valid_q;
      first_err_cyc_d   = first_err_cyc_q;
      ill_hit           = s & r;
      err_hit           = (state_q == TRACK) && ((q != exp_q_q) || (q == qbar));
      // In SYNC the model is unknown, so it is seeded from the observed q.
      model_base        = (state_q == SYNC) ? q : exp_q_q;

      if (clr) begin
         state_d           = SYNC;
         err_count_d       = '0;
         illegal_count_d   = '0;
         cyc_count_d       = '0;
         first_err_valid_d = 1'b0;
         first_err_cyc_d   = '0;
      end else if (en) begin
         mismatch_d  = err_hit;
         illegal_d   = ill_hit;
         cyc_count_d = cyc_count_q + 1'b1;
         if (err_hit && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
         end
         if (ill_hit && (illegal_count_q != '1)) begin
            illegal_count_d = illegal_count_q + 1'b1;
         end
         if (err_hit && !first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_cyc_d   = cyc_count_q;
         end
         if (ill_hit) begin
            state_d = SYNC;
         end else begin
            state_d = TRACK;
            exp_q_d = s ? 1'b1 : (r ? 1'b0 : model_base);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= SYNC;
         exp_q_q           <= 1'b0;
         mismatch_q        <= 1'b0;
         illegal_q         <= 1'b0;
         err_count_q       <= '0;
         illegal_count_q   <= '0;
         cyc_count_q       <= '0;
         first_err_valid_q <= 1'b0;
         first_err_cyc_q   <= '0;
      end else begin
         state_q           <= state_d;
         exp_q_q           <= exp_q_d;
         mismatch_q        <= mismatch_d;
         illegal_q         <= illegal_d;
         err_count_q       <= err_count_d;
         illegal_count_q   <= illegal_count_d;
         cyc_count_q       <= cyc_count_d;
         first_err_valid_q <= first_err_valid_d;
         first_err_cyc_q   <= first_err_cyc_d;
      end
   end

   assign exp_q           = exp_q_q;
   assign synced          = (state_q == TRACK);
   assign mismatch        = mismatch_q;
   assign illegal         = illegal_q;
   assign err_count       = err_count_q;
   assign illegal_count   = illegal_count_q;
   assign cyc_count       = cyc_count_q;
   assign first_err_valid = first_err_valid_q;
   assign first_err_cyc   = first_err_cyc_q;

endmodule
